// File: rtl/ecc_scrub_ctrl_pkg.sv
// Shared definitions for the ECC scrub controller and the memory words it serves.
package ecc_scrub_ctrl_pkg;

  // Data word width shared with ecc_mem_word.
  localparam int WORD_W = 20;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RESP,
    SCRUB,
    WB
  } state_t;

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// CPU access bus of the scrub controller: request/ready handshake plus data.
interface ecc_scrub_ctrl_if
  import ecc_scrub_ctrl_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = 8
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WIDTH-1:0]  cpu_wdata;
  logic [WIDTH-1:0]  cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;

  // Requester side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_err
  );

  // Controller side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_err
  );

endinterface

// File: rtl/ecc_scrub_ctrl_timer.sv
// Scrub-request timer: INTERVAL-cycle down-counter that raises a sticky
// scrub_pend flag on each expiry; the flag clears when the scrub starts.
module ecc_scrub_timer #(
  parameter int INTERVAL = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic scrub_pend
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = (cnt == '0);

  // Count down, reload on expiry, and track a single pending scrub request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= RELOAD;
      scrub_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt        <= tick ? RELOAD : cnt - CW'(1);
      // Entering SCRUB wins over a coincident tick; extra ticks are not counted.
      scrub_pend <= clr ? 1'b0 : (scrub_pend | tick);
    end
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ECC scrub controller: serves single-word CPU reads/writes into an array of
// voting memory words and, when idle, walks the array writing back any word
// that reports an error. Each write-back bumps a saturating repair counter.
module ecc_scrub_ctrl
  import ecc_scrub_ctrl_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int INTERVAL = 1024,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ecc_scrub_ctrl_if.slave   cpu,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_err,
  output logic [CNT_W-1:0]  repair_cnt,
  output logic [ADDR_W-1:0] scrub_ptr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic              scrub_pend;
  logic              scrub_clr;
  logic [WIDTH-1:0]  rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr;
  logic [WIDTH-1:0]  wb_data;

  ecc_scrub_timer #(
    .INTERVAL (INTERVAL)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (scrub_clr),
    .scrub_pend (scrub_pend)
  );

  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_err   = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and memory/CPU strobes.
  always_comb begin
    // NOTE: every output gets a default first so no branch can infer a latch.
    state_next    = state;
    mem_addr      = scrub_ptr;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    cpu.cpu_ready = 1'b0;
    scrub_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu.cpu_req) begin
          state_next = ACCESS;
        end else if (scrub_pend) begin
          state_next = SCRUB;
          scrub_clr  = 1'b1;
        end
      end
      ACCESS: begin
        mem_addr   = cpu.cpu_addr;
        mem_we     = cpu.cpu_we;
        mem_wdata  = cpu.cpu_wdata;
        state_next = RESP;
      end
      RESP: begin
        cpu.cpu_ready = 1'b1;
        state_next    = err_q ? WB : IDLE;
      end
      SCRUB: begin
        mem_addr   = scrub_ptr;
        state_next = mem_err ? WB : IDLE;
      end
      WB: begin
        mem_addr   = err_addr;
        mem_we     = 1'b1;
        mem_wdata  = wb_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture read results, pick the write-back source, advance the
  // scrub pointer and count repairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well so every output reads 0 in reset.
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr   <= '0;
      wb_data    <= '0;
      scrub_ptr  <= '0;
      repair_cnt <= '0;
    end else begin
      case (state)
        ACCESS: begin
          rdata_q  <= mem_rdata;
          err_q    <= mem_err & ~cpu.cpu_we;
          err_addr <= cpu.cpu_addr;
          wb_data  <= mem_rdata;
        end
        SCRUB: begin
          wb_data   <= mem_rdata;
          err_addr  <= scrub_ptr;
          scrub_ptr <= (scrub_ptr == LAST_ADDR) ? '0 : scrub_ptr + ADDR_W'(1);
        end
        WB: begin
          if (repair_cnt != '1) repair_cnt <= repair_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
